// File: rtl/seg7_decode_capture_pkg.sv
// Shared constants for the 7-segment capture block: segment patterns for hex digits,
// the all-off pattern, and the capture FSM state encoding.
package seg7_decode_capture_pkg;

   // Active-low g..a patterns, indexed by the hex value they display.
   localparam logic [6:0] SEG_PAT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   localparam logic [6:0] BLANK_PAT = 7'h7F;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HELD   = 2'd2
   } stateT;

endpackage

// File: rtl/seg7_decode_capture_pat_decode.sv
// Combinational 7-segment pattern decoder: pattern -> {hex digit, blank, undecodable}.
module seg7_pat_decode
   import seg7_decode_capture_pkg::*;
(
   input  logic [6:0] iPat,
   output logic [3:0] oDigit,
   output logic       oBlank,
   output logic       oErr
);

   logic hit;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      oDigit = 4'd0;
      hit    = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (iPat == SEG_PAT[i]) begin
            oDigit = 4'(i);
            hit    = 1'b1;
         end
      end
      oBlank = (iPat == BLANK_PAT);
      oErr   = !hit && !oBlank;
   end

endmodule

// File: rtl/seg7_decode_capture.sv
// Samples a multiplexed 7-segment display bus and reconstructs the shown digits as an atomic frame.
// Define SEG7_DECODE_DP_EN to add the oDP output (decimal point per digit).
module seg7_decode_capture
   import seg7_decode_capture_pkg::*;
#(
   parameter int N_DIG      = 4,
   parameter int STABLE_CYC = 4
) (
   input  logic                 iCLK,
   input  logic                 iRST,
   input  logic [7:0]           iSEG,
   input  logic [N_DIG-1:0]     iAN,
   output logic [4*N_DIG-1:0]   oDIG,
   output logic [N_DIG-1:0]     oBLANK,
   output logic [N_DIG-1:0]     oERR,
   output logic                 oFRAME
`ifdef SEG7_DECODE_DP_EN
   ,
   output logic [N_DIG-1:0]     oDP
`endif
);

   localparam int CNT_W = (STABLE_CYC < 1) ? 1 : $clog2(STABLE_CYC + 1);
   localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);

   logic [7:0]       segIn;
   logic [7:0]       segMeta, segSync, segPrev;
   logic [N_DIG-1:0] anMeta, anSync, anPrev;

`ifdef SEG7_DECODE_DP_EN
   assign segIn = iSEG;
`else
   // Tie dp inactive so it can never register as a change.
   logic unusedDp;
   assign unusedDp = iSEG[7];
   assign segIn    = {1'b1, iSEG[6:0]};
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         segMeta <= '1;
         segSync <= '1;
         segPrev <= '1;
         anMeta  <= '1;
         anSync  <= '1;
         anPrev  <= '1;
      end else begin
         segMeta <= segIn;
         segSync <= segMeta;
         segPrev <= segSync;
         anMeta  <= iAN;
         anSync  <= anMeta;
         anPrev  <= anSync;
      end
   end

   logic             changed, oneLow;
   logic [IDX_W-1:0] digIdx;

   assign changed = (segSync != segPrev) || (anSync != anPrev);
   assign oneLow  = $onehot(~anSync);

   always_comb begin
      digIdx = '0;
      for (int k = 0; k < N_DIG; k++) begin
         if (!anSync[k]) digIdx = IDX_W'(k);
      end
   end

   logic [3:0] decDigit;
   logic       decBlank, decErr;

   seg7_pat_decode uDecode (
      .iPat   (segSync[6:0]),
      .oDigit (decDigit),
      .oBlank (decBlank),
      .oErr   (decErr)
   );

   stateT            state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext;
   logic             capture;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      capture   = 1'b0;
      unique case (state)
         IDLE: begin
            if (oneLow) begin
               stateNext = SETTLE;
               cntNext   = CNT_W'(1);
            end
         end
         SETTLE, HELD: begin
            if (changed) begin
               if (oneLow) begin
                  stateNext = SETTLE;
                  cntNext   = CNT_W'(1);
               end else begin
                  stateNext = IDLE;
                  cntNext   = '0;
               end
            end else if (state == SETTLE) begin
               if (cnt >= CNT_MAX) begin
                  capture   = 1'b1;
                  stateNext = HELD;
               end else begin
                  cntNext = cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
      endcase
   end

   logic [4*N_DIG-1:0] shDig;
   logic [N_DIG-1:0]   shBlank, shErr, seen;
   logic               seenAll;

   assign seenAll = &seen;

`ifdef SEG7_DECODE_DP_EN
   logic [N_DIG-1:0] shDp;
`endif

   // NOTE: the shadow slots are reset too, so a frame begun before reset can never leak stale digits.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         shDig   <= '0;
         shBlank <= '0;
         shErr   <= '0;
         seen    <= '0;
         oDIG    <= '0;
         oBLANK  <= '1;
         oERR    <= '0;
         oFRAME  <= 1'b0;
`ifdef SEG7_DECODE_DP_EN
         shDp    <= '0;
         oDP     <= '0;
`endif
      end else begin
         oFRAME <= seenAll;
         if (seenAll) begin
            oDIG   <= shDig;
            oBLANK <= shBlank;
            oERR   <= shErr;
            seen   <= '0;
`ifdef SEG7_DECODE_DP_EN
            oDP    <= shDp;
`endif
         end
         // Placed after the clear so a capture on the frame edge survives into the next frame.
         if (capture) begin
            shDig[{digIdx, 2'b00} +: 4] <= decDigit;
            shBlank[digIdx]             <= decBlank;
            shErr[digIdx]               <= decErr;
            seen[digIdx]                <= 1'b1;
`ifdef SEG7_DECODE_DP_EN
            shDp[digIdx]                <= ~segSync[7];
`endif
         end
      end
   end

endmodule

// File: tb/tb_seg7_decode_capture.sv
// Scoreboard bench for seg7_decode_capture: stimulus pushes expected frames, a monitor checks each oFRAME.
module tb_seg7_decode_capture;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic [7:0]  iSEG;
   logic [3:0]  iAN;
   logic [15:0] oDIG;
   logic [3:0]  oBLANK, oERR;
   logic        oFRAME;
`ifdef SEG7_DECODE_DP_EN
   logic [3:0]  oDP;
`endif

   seg7_decode_capture #(.N_DIG(4), .STABLE_CYC(4)) dut (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .iSEG   (iSEG),
      .iAN    (iAN),
      .oDIG   (oDIG),
      .oBLANK (oBLANK),
      .oERR   (oERR),
      .oFRAME (oFRAME)
`ifdef SEG7_DECODE_DP_EN
      ,
      .oDP    (oDP)
`endif
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      logic [15:0] dig;
      logic [3:0]  blank;
      logic [3:0]  err;
      logic [3:0]  dp;
   } frameT;

   frameT expQ[$];
   int    compared   = 0;
   int    mismatched = 0;
   int    frameCnt   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic pushFrame(input logic [15:0] dig, input logic [3:0] blank,
                            input logic [3:0] err, input logic [3:0] dp);
      frameT f;
      f.dig   = dig;
      f.blank = blank;
      f.err   = err;
      f.dp    = dp;
      expQ.push_back(f);
   endtask

   task automatic showDigit(input int k, input logic [7:0] seg, input int cyc);
      logic [3:0] an;
      an      = 4'hF;
      an[k]   = 1'b0;
      iAN     = an;
      iSEG    = seg;
      repeat (cyc) @(negedge iCLK);
   endtask

   task automatic idle(input int cyc);
      iAN  = 4'hF;
      iSEG = 8'hFF;
      repeat (cyc) @(negedge iCLK);
   endtask

   task automatic checkResetOutputs(input string tag);
      check({tag, " oDIG"},   32'(oDIG),   32'h0);
      check({tag, " oBLANK"}, 32'(oBLANK), 32'hF);
      check({tag, " oERR"},   32'(oERR),   32'h0);
      check({tag, " oFRAME"}, 32'(oFRAME), 32'h0);
`ifdef SEG7_DECODE_DP_EN
      check({tag, " oDP"},    32'(oDP),    32'h0);
`endif
   endtask

   // Monitor: compares each frame against the scoreboard and checks outputs hold between frames.
   logic [23:0] heldOut;
   always @(negedge iCLK) begin
      if (iRST) begin
         heldOut = {oDIG, oBLANK, oERR};
      end else if (oFRAME) begin
         frameCnt++;
         if (expQ.size() == 0) begin
            check("unexpected frame", 32'(frameCnt), 32'h0);
         end else begin
            frameT e;
            e = expQ.pop_front();
            check("frame oDIG",   32'(oDIG),   32'(e.dig));
            check("frame oBLANK", 32'(oBLANK), 32'(e.blank));
            check("frame oERR",   32'(oERR),   32'(e.err));
`ifdef SEG7_DECODE_DP_EN
            check("frame oDP",    32'(oDP),    32'(e.dp));
`endif
         end
         heldOut = {oDIG, oBLANK, oERR};
      end else begin
         check("outputs hold", 32'({oDIG, oBLANK, oERR}), 32'(heldOut));
      end
   end

   initial begin
      iRST = 1'b1;
      iSEG = 8'hFF;
      iAN  = 4'hF;
      repeat (3) @(negedge iCLK);
      checkResetOutputs("reset");
      iRST = 1'b0;
      idle(4);

      // Digits 0..3 show 4,3,2,1.
      pushFrame(16'h1234, 4'b0000, 4'b0000, 4'b0000);
      showDigit(0, 8'h99, 8);
      showDigit(1, 8'hB0, 8);
      showDigit(2, 8'hA4, 8);
      showDigit(3, 8'hF9, 8);
      idle(12);

      // Segments toggling every 2 cycles, then two strobes low: neither may capture digit 0.
      for (int i = 0; i < 10; i++) begin
         showDigit(0, (i % 2 == 0) ? 8'hC0 : 8'hF9, 2);
      end
      iAN  = 4'b1100;
      iSEG = 8'h99;
      repeat (10) @(negedge iCLK);
      showDigit(1, 8'hD5, 8);
      showDigit(2, 8'hFF, 8);
      showDigit(3, 8'h88, 8);
      idle(20);
      check("no frame without digit 0", 32'(frameCnt), 32'd1);

      // Digit 0 shows '1' with dp lit: completes frame with blank digit 2 and bad digit 1.
      pushFrame(16'hA001, 4'b0100, 4'b0010, 4'b0001);
      showDigit(0, 8'h79, 8);
      idle(12);

      // Digit 0 recaptured within the frame: latest value wins.
      pushFrame(16'h9876, 4'b0000, 4'b0000, 4'b0000);
      showDigit(0, 8'h92, 8);
      showDigit(0, 8'h82, 8);
      showDigit(1, 8'hF8, 8);
      showDigit(2, 8'h80, 8);
      showDigit(3, 8'h98, 8);
      idle(12);
      check("frames before reset test", 32'(frameCnt), 32'd3);

      // Reset after three captures discards them; digit 3 alone must not complete a frame.
      showDigit(0, 8'hC6, 8);
      showDigit(1, 8'hA1, 8);
      showDigit(2, 8'h86, 8);
      idle(1);
      iRST = 1'b1;
      repeat (3) @(negedge iCLK);
      checkResetOutputs("mid reset");
      iRST = 1'b0;
      idle(3);
      showDigit(3, 8'h8E, 8);
      idle(20);
      check("no frame after partial", 32'(frameCnt), 32'd3);
      checkResetOutputs("post reset");

      pushFrame(16'hFEDC, 4'b0000, 4'b0000, 4'b0000);
      showDigit(0, 8'hC6, 8);
      showDigit(1, 8'hA1, 8);
      showDigit(2, 8'h86, 8);
      idle(20);

      check("frames missing", 32'(expQ.size()), 32'd0);
      check("total frames", 32'(frameCnt), 32'd4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
